// File: rtl/de_instr_q.sv
// Decode-side instruction queue: buffers fetched packets and presents them in order to decode.
// Optional same-cycle fetch-to-decode bypass through an empty queue: define DE_IQ_BYPASS_EN.

package de_instr_q_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  simid;
        logic [31:0] opcode;
    } t_instr_pkt;

    // The queue only consumes the valid bit of the flush requests.
    typedef struct packed {
        logic valid;
    } t_nuke_pkt;

    typedef struct packed {
        logic valid;
    } t_br_mispred_pkt;

endpackage

module de_instr_q
    import de_instr_q_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  t_nuke_pkt                  nuke_rb1,
    input  t_br_mispred_pkt            br_mispred_ex0,
    input  logic                       valid_fe1,
    input  t_instr_pkt                 instr_fe1,
    output logic                       decode_ready_de0,
    output logic                       valid_de1,
    output t_instr_pkt                 instr_de1,
    input  logic                       ready_de1,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_de1
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    t_instr_pkt     mem_r [DEPTH];
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  wr_ptr_r;
    logic [CW-1:0]  count_r;

    logic           flush_s;
    logic           empty_s;
    logic           push_s;
    logic           pop_s;
    logic           wr_en_s;
    logic           rd_adv_s;
    logic           valid_s;
    t_instr_pkt     head_s;

    assign flush_s          = nuke_rb1.valid | br_mispred_ex0.valid;
    assign empty_s          = (count_r == {CW{1'b0}});
    assign decode_ready_de0 = ~reset & (count_r != CW'(DEPTH));
    assign occupancy_de1    = reset ? {CW{1'b0}} : count_r;

    // Head selection toward decode; flush and reset force the output invalid.
    always_comb begin
        valid_s = 1'b0;
        head_s  = '0;
        if (reset | flush_s) begin
            valid_s = 1'b0;
            head_s  = '0;
        end else if (!empty_s) begin
            valid_s = 1'b1;
            head_s  = mem_r[rd_ptr_r];
        end else begin
`ifdef DE_IQ_BYPASS_EN
            valid_s = valid_fe1;
            head_s  = valid_fe1 ? instr_fe1 : '0;
`else
            valid_s = 1'b0;
            head_s  = '0;
`endif
        end
    end

    assign valid_de1 = valid_s;
    assign instr_de1 = head_s;

    assign push_s   = valid_fe1 & decode_ready_de0 & ~flush_s;
    assign pop_s    = valid_s & ready_de1 & ~flush_s;
    // A pop from an empty queue can only be a bypassed packet; it is never written.
    assign wr_en_s  = push_s & ~(empty_s & pop_s);
    assign rd_adv_s = pop_s & ~empty_s;

    // Pointer and count state; flush has priority over push and pop.
    always_ff @(posedge clk) begin
        if (reset | flush_s) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({wr_en_s, rd_adv_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= instr_fe1;
        end
    end

endmodule

// File: tb/tb_de_instr_q.sv
// Self-checking bench for de_instr_q: scoreboard of accepted packets plus per-scenario checks.
// Covers both builds; bypass expectations follow DE_IQ_BYPASS_EN.

module tb_de_instr_q;
    import de_instr_q_pkg::*;

    localparam int DEPTH = 4;
`ifdef DE_IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    t_nuke_pkt       nuke_rb1;
    t_br_mispred_pkt br_mispred_ex0;
    logic            valid_fe1;
    t_instr_pkt      instr_fe1;
    logic            decode_ready_de0;
    logic            valid_de1;
    t_instr_pkt      instr_de1;
    logic            ready_de1;
    logic [2:0]      occupancy_de1;

    int         checks = 0;
    int         failures = 0;
    t_instr_pkt sb[$];
    bit         last_acc;
    int         next_id = 0;

    de_instr_q #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .nuke_rb1         (nuke_rb1),
        .br_mispred_ex0   (br_mispred_ex0),
        .valid_fe1        (valid_fe1),
        .instr_fe1        (instr_fe1),
        .decode_ready_de0 (decode_ready_de0),
        .valid_de1        (valid_de1),
        .instr_de1        (instr_de1),
        .ready_de1        (ready_de1),
        .occupancy_de1    (occupancy_de1)
    );

    always #5 clk = ~clk;

    function automatic t_instr_pkt mk(int id);
        t_instr_pkt p;
        p.pc     = 32'h100 + 32'(id) * 32'd4;
        p.simid  = 8'(id);
        p.opcode = 32'hA500_0000 ^ 32'(id);
        return p;
    endfunction

    // One clock: compare outputs against the reference queue, then advance the reference.
    task automatic step();
        t_instr_pkt exp_i;
        bit fl, ev, er, popd;
        int eo;
        @(negedge clk);
        fl = nuke_rb1.valid | br_mispred_ex0.valid;
        er = !reset && (sb.size() != DEPTH);
        eo = reset ? 0 : sb.size();
        ev = !reset && !fl && ((sb.size() != 0) || (BYP && valid_fe1));
        exp_i = '0;
        if (ev) exp_i = (sb.size() != 0) ? sb[0] : instr_fe1;
        checks += 4;
        if (decode_ready_de0 !== er) begin
            failures++; $display("FAIL sb_ready: got %b want %b", decode_ready_de0, er);
        end
        if (occupancy_de1 !== 3'(eo)) begin
            failures++; $display("FAIL sb_occupancy: got %0d want %0d", occupancy_de1, eo);
        end
        if (valid_de1 !== ev) begin
            failures++; $display("FAIL sb_valid: got %b want %b", valid_de1, ev);
        end
        if (instr_de1 !== exp_i) begin
            failures++; $display("FAIL sb_instr: got pc=%h simid=%0d want pc=%h simid=%0d",
                                 instr_de1.pc, instr_de1.simid, exp_i.pc, exp_i.simid);
        end
        last_acc = valid_fe1 && er && !fl;
        popd     = ev && ready_de1;
        if (reset || fl) begin
            sb.delete();
        end else begin
            if (last_acc) sb.push_back(instr_fe1);
            if (popd) void'(sb.pop_front());
        end
        @(posedge clk); #1;
    endtask

    task automatic fill(int n);
        int acc = 0;
        ready_de1 = 1'b0;
        for (int i = 0; i < n + 3 && acc < n; i++) begin
            valid_fe1 = 1'b1;
            instr_fe1 = mk(next_id);
            step();
            if (last_acc) begin acc++; next_id++; end
        end
        valid_fe1 = 1'b0;
        checks++;
        if (acc !== n) begin
            failures++; $display("FAIL fill_count: got %0d want %0d", acc, n);
        end
    endtask

    task automatic drain(int n);
        valid_fe1 = 1'b0;
        ready_de1 = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (decode_ready_de0 !== 1'b0 || valid_de1 !== 1'b0 || occupancy_de1 !== 3'd0) begin
            failures++; $display("FAIL reset_outputs: got rdy=%b vld=%b occ=%0d want 0 0 0",
                                 decode_ready_de0, valid_de1, occupancy_de1);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (decode_ready_de0 !== 1'b1) begin
            failures++; $display("FAIL reset_release_ready: got %b want 1", decode_ready_de0);
        end
        step();
    endtask

    task automatic test_single();
        ready_de1 = 1'b1;
        valid_fe1 = 1'b1;
        instr_fe1 = mk(next_id);
        #1;
        checks++;
`ifdef DE_IQ_BYPASS_EN
        if (valid_de1 !== 1'b1 || instr_de1.pc !== 32'h100) begin
            failures++; $display("FAIL single_bypass: got vld=%b pc=%h want 1 100", valid_de1, instr_de1.pc);
        end
`else
        if (valid_de1 !== 1'b0) begin
            failures++; $display("FAIL single_latency: got vld=%b want 0", valid_de1);
        end
`endif
        step();
        next_id++;
        valid_fe1 = 1'b0;
        #1;
        checks++;
`ifdef DE_IQ_BYPASS_EN
        if (occupancy_de1 !== 3'd0 || valid_de1 !== 1'b0) begin
            failures++; $display("FAIL single_bypass_occ: got occ=%0d vld=%b want 0 0", occupancy_de1, valid_de1);
        end
`else
        if (valid_de1 !== 1'b1 || instr_de1.pc !== 32'h100 || occupancy_de1 !== 3'd1) begin
            failures++; $display("FAIL single_visible: got vld=%b pc=%h occ=%0d want 1 100 1",
                                 valid_de1, instr_de1.pc, occupancy_de1);
        end
`endif
        step();
        checks++;
        if (occupancy_de1 !== 3'd0) begin
            failures++; $display("FAIL single_empty: got occ=%0d want 0", occupancy_de1);
        end
    endtask

    task automatic test_fill();
        int occ_at = -1;
        fill(DEPTH);
        checks++;
        if (decode_ready_de0 !== 1'b0 || occupancy_de1 !== 3'd4) begin
            failures++; $display("FAIL fill_full: got rdy=%b occ=%0d want 0 4", decode_ready_de0, occupancy_de1);
        end
        valid_fe1 = 1'b1;
        instr_fe1 = mk(next_id);
        step();
        checks++;
        if (last_acc !== 1'b0) begin
            failures++; $display("FAIL fill_hold: got accepted=%b want 0", last_acc);
        end
        ready_de1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int occ;
            occ = occupancy_de1;
            step();
            if (last_acc) begin
                occ_at = occ; next_id++; valid_fe1 = 1'b0; break;
            end
        end
        checks++;
        if (occ_at !== 3) begin
            failures++; $display("FAIL fill_fifth: got occ_at_accept=%0d want 3", occ_at);
        end
        drain(6);
    endtask

    task automatic test_steady();
        fill(2);
        ready_de1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            valid_fe1 = 1'b1;
            instr_fe1 = mk(next_id);
            #1;
            checks++;
            if (occupancy_de1 !== 3'd2) begin
                failures++; $display("FAIL steady_occ: cycle %0d got %0d want 2", i, occupancy_de1);
            end
            step();
            if (last_acc) next_id++;
        end
        drain(4);
    endtask

    task automatic test_nuke();
        fill(3);
        nuke_rb1.valid = 1'b1;
        valid_fe1 = 1'b1;
        instr_fe1 = mk(next_id);
        ready_de1 = 1'b1;
        #1;
        checks++;
        if (valid_de1 !== 1'b0) begin
            failures++; $display("FAIL nuke_valid: got %b want 0", valid_de1);
        end
        step();
        next_id++;
        nuke_rb1.valid = 1'b0;
        valid_fe1 = 1'b0;
        #1;
        checks++;
        if (occupancy_de1 !== 3'd0 || valid_de1 !== 1'b0 || decode_ready_de0 !== 1'b1) begin
            failures++; $display("FAIL nuke_after: got occ=%0d vld=%b rdy=%b want 0 0 1",
                                 occupancy_de1, valid_de1, decode_ready_de0);
        end
        drain(2);
    endtask

    task automatic test_mispred();
        fill(DEPTH);
        br_mispred_ex0.valid = 1'b1;
        step();
        br_mispred_ex0.valid = 1'b0;
        #1;
        checks++;
        if (decode_ready_de0 !== 1'b1 || occupancy_de1 !== 3'd0) begin
            failures++; $display("FAIL mispred_after: got rdy=%b occ=%0d want 1 0", decode_ready_de0, occupancy_de1);
        end
        valid_fe1 = 1'b1;
        instr_fe1 = mk(next_id);
        ready_de1 = 1'b1;
        step();
        if (last_acc) next_id++;
        drain(3);
    endtask

    task automatic test_reset_mid();
        fill(2);
        reset = 1'b1;
        #1;
        checks++;
        if (decode_ready_de0 !== 1'b0 || valid_de1 !== 1'b0 || instr_de1 !== '0 || occupancy_de1 !== 3'd0) begin
            failures++; $display("FAIL reset_mid_outputs: got rdy=%b vld=%b pc=%h occ=%0d want 0 0 0 0",
                                 decode_ready_de0, valid_de1, instr_de1.pc, occupancy_de1);
        end
        step();
        step();
        reset = 1'b0;
        ready_de1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (valid_de1 !== 1'b0) begin
                failures++; $display("FAIL reset_mid_stale: cycle %0d got vld=%b want 0", i, valid_de1);
            end
            step();
        end
        valid_fe1 = 1'b1;
        instr_fe1 = mk(next_id);
        step();
        if (last_acc) next_id++;
        drain(3);
    endtask

    initial begin
        reset                = 1'b1;
        nuke_rb1             = '0;
        br_mispred_ex0       = '0;
        valid_fe1            = 1'b0;
        instr_fe1            = '0;
        ready_de1            = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_steady();
        test_nuke();
        test_mispred();
        test_reset_mid();
        checks++;
        if (sb.size() !== 0) begin
            failures++; $display("FAIL final_empty: got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
